// File: rtl/dm_bus_responder.sv
// Data-memory responder for the CPU load/store port: one outstanding byte/half/word
// access, fixed latency, valid/ready handshakes on both request and response.
module dm_bus_responder #(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_op,
   input  logic        req_sext,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  op_q, op_d;
   logic        sext_q, sext_d;
   logic        valid_q, valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [0:DEPTH-1];

   logic [DEPTH_LOG2-1:0] word_idx;
   logic [31:0] rd_word, byte_sh, half_sh, load_val, merge_word;
   logic        acc_err, mem_we;

   assign word_idx = addr_q[DEPTH_LOG2+1:2];
   assign rd_word  = mem_q[word_idx];
   assign byte_sh  = rd_word >> {addr_q[1:0], 3'b000};
   assign half_sh  = rd_word >> {addr_q[1], 4'b0000};

   assign acc_err = (op_q == 2'b11)
                 || (op_q == 2'b00 && addr_q[1:0] != 2'b00)
                 || (op_q == 2'b01 && addr_q[0])
                 || (|addr_q[31:DEPTH_LOG2+2]);

   // Load extraction and store lane merge both work from the addressed word.
   always_comb begin
      load_val   = '0;
      merge_word = rd_word;
      case (op_q)
         2'b00: begin
            load_val   = rd_word;
            merge_word = wdata_q;
         end
         2'b01: begin
            load_val = {{16{sext_q & half_sh[15]}}, half_sh[15:0]};
            merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         2'b10: begin
            load_val = {{24{sext_q & byte_sh[7]}}, byte_sh[7:0]};
            merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      sext_d  = sext_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            op_d    = req_op;
            sext_d  = req_sext;
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
         end else begin
            valid_d = 1'b1;
            err_d   = acc_err;
            rdata_d = (acc_err || we_q) ? 32'd0 : load_val;
            mem_we  = we_q && !acc_err;
            state_d = RESP;
         end
         RESP: if (resp_ready) begin
            valid_d = 1'b0;
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= '0;
         sext_q  <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         // NOTE: the memory must read back zero after reset, so it is built from
         // resettable flops rather than an inferred RAM macro.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         sext_q  <= sext_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (mem_we) mem_q[word_idx] <= merge_word;
      end
   end

   assign req_ready  = (state_q == IDLE) && !reset;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Bench for dm_bus_responder: directed load/store scenarios plus randomized traffic
// checked against a byte-array memory model.
module tb_dm_bus_responder;

   localparam int DL  = 12;
   localparam int LAT = 2;
   localparam int BYTES = 4 << DL;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_sext;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_op;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   int checks = 0;
   int errors = 0;
   bit [7:0] mem_m [0:BYTES-1];

   dm_bus_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_op     (req_op),
      .req_sext   (req_sext),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_clear();
      foreach (mem_m[i]) mem_m[i] = 8'h00;
   endfunction

   // Byte-level reference: size from op, alignment by modulo, little-endian bytes.
   function automatic void model(input bit we, input bit [31:0] a, input bit [31:0] wd,
                                 input bit [1:0] op, input bit sx,
                                 output bit [31:0] rd, output bit er);
      int unsigned size;
      size = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
      er = (op == 2'd3) || (a % size != 0) || (a >= 32'(BYTES));
      rd = '0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < int'(size); i++) mem_m[a + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < int'(size); i++) rd[8*i +: 8] = mem_m[a + i];
            if (sx && size < 4 && rd[8*size-1])
               for (int i = int'(size); i < 4; i++) rd[8*i +: 8] = 8'hFF;
         end
      end
   endfunction

   task automatic transact(input bit we, input bit [31:0] a, input bit [31:0] wd,
                           input bit [1:0] op, input bit sx, input int hold,
                           output bit [31:0] rd_out, output bit er_out);
      bit [31:0]   erd;
      bit          eer;
      int          n;
      logic [31:0] held_rd;
      logic        held_er;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_op    = op;
      req_sext  = sx;
      @(posedge clk);
      model(we, a, wd, op, sx, erd, eer);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      check("no_early_valid", 32'(resp_valid), 32'd0);
      n = 0;
      while (!resp_valid && n < 4 * LAT + 4) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, LAT);
      check("rdata", resp_rdata, erd);
      check("err", 32'(resp_err), 32'(eer));
      rd_out  = resp_rdata;
      er_out  = resp_err;
      held_rd = resp_rdata;
      held_er = resp_err;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_addr  = 32'h4;
         req_wdata = 32'hFFFF_FFFF;
         req_op    = 2'b00;
         @(negedge clk);
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_rdata", resp_rdata, held_rd);
         check("bp_err", 32'(resp_err), 32'(held_er));
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check("resp_drop", 32'(resp_valid), 32'd0);
      check("idle_after_resp", 32'(req_ready), 32'd1);
      check("rdata_cleared", resp_rdata, 32'd0);
      req_valid  = 1'b0;
      resp_ready = 1'b0;
   endtask

   bit [31:0] rd;
   bit        er;
   int        seen_valid;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_op = '0; req_sext = 1'b0; resp_ready = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_rdata", resp_rdata, 32'd0);
      check("reset_err", 32'(resp_err), 32'd0);
      reset = 1'b0;

      transact(1, 32'h4, 32'h1234_5678, 2'b00, 0, 0, rd, er);
      transact(0, 32'h4, 32'h0, 2'b00, 0, 0, rd, er);
      check("t1_lw", rd, 32'h1234_5678);

      transact(1, 32'h7, 32'h0000_00AB, 2'b10, 0, 0, rd, er);
      transact(0, 32'h7, 32'h0, 2'b10, 1, 0, rd, er);
      check("t2_lb", rd, 32'hFFFF_FFAB);
      transact(0, 32'h7, 32'h0, 2'b10, 0, 0, rd, er);
      check("t2_lbu", rd, 32'h0000_00AB);
      transact(0, 32'h4, 32'h0, 2'b00, 0, 0, rd, er);
      check("t2_lw", rd, 32'hAB34_5678);

      transact(1, 32'h6, 32'h0000_BEEF, 2'b01, 0, 0, rd, er);
      transact(0, 32'h6, 32'h0, 2'b01, 1, 0, rd, er);
      check("t3_lh", rd, 32'hFFFF_BEEF);
      transact(0, 32'h6, 32'h0, 2'b01, 0, 0, rd, er);
      check("t3_lhu", rd, 32'h0000_BEEF);
      transact(0, 32'h4, 32'h0, 2'b00, 0, 0, rd, er);
      check("t3_lw", rd, 32'hBEEF_5678);

      transact(0, 32'h2, 32'h0, 2'b00, 0, 0, rd, er);
      check("t4_lw_mis_err", 32'(er), 32'd1);
      transact(1, 32'h5, 32'hFFFF_FFFF, 2'b01, 0, 0, rd, er);
      check("t4_sh_mis_err", 32'(er), 32'd1);
      transact(1, 32'h4, 32'hFFFF_FFFF, 2'b11, 0, 0, rd, er);
      check("t4_illegal_err", 32'(er), 32'd1);
      transact(1, 32'h0001_0000, 32'hFFFF_FFFF, 2'b00, 0, 0, rd, er);
      check("t4_range_err", 32'(er), 32'd1);
      transact(0, 32'h4, 32'h0, 2'b00, 0, 0, rd, er);
      check("t4_lw_unchanged", rd, 32'hBEEF_5678);

      transact(0, 32'h4, 32'h0, 2'b00, 0, 5, rd, er);
      transact(0, 32'h4, 32'h0, 2'b00, 0, 0, rd, er);
      check("t5_no_second_accept", rd, 32'hBEEF_5678);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
      req_op = 2'b00; req_sext = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("t6_ready_in_reset", 32'(req_ready), 32'd0);
      reset = 1'b0;
      model_clear();
      seen_valid = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) seen_valid++;
      end
      check("t6_no_resp", seen_valid, 0);
      transact(0, 32'h8, 32'h0, 2'b00, 0, 0, rd, er);
      check("t6_lw8", rd, 32'h0);
      transact(0, 32'h4, 32'h0, 2'b00, 0, 0, rd, er);
      check("t6_lw4", rd, 32'h0);

      for (int t = 0; t < 250; t++) begin
         bit [31:0] a;
         bit [1:0]  op;
         int        r;
         r = $urandom_range(0, 15);
         if (r == 0)      a = $urandom;
         else if (r == 1) a = 32'h3FFC + $urandom_range(0, 7);
         else             a = $urandom_range(0, 31);
         op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         transact(1'($urandom_range(0, 1)), a, $urandom, op, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), rd, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
